// File: rtl/rs_sched_pkg.sv
// Shared widths, defaults and record types for the reservation-station scheduler.
package rs_sched_pkg;

   localparam int INS_OP_W     = 6;
   localparam int REG_DAT_W    = 32;
   localparam int ROB_ADD_W    = 4;
   localparam int RS_SIZE_DEF  = 16;
   localparam int RS_IDX_W_DEF = 4;

   typedef struct packed {
      logic                 en;
      logic [ROB_ADD_W-1:0] qd;
      logic [REG_DAT_W-1:0] vd;
   } cdb_t;

   typedef struct packed {
      logic                 rdy;
      logic [REG_DAT_W-1:0] v;
      logic [ROB_ADD_W-1:0] q;
   } opnd_t;

   typedef struct packed {
      logic [INS_OP_W-1:0]  op;
      logic [REG_DAT_W-1:0] pc;
      logic [REG_DAT_W-1:0] imm;
      opnd_t                s1;
      opnd_t                s2;
      logic [ROB_ADD_W-1:0] qd;
   } ent_t;

   typedef struct packed {
      logic [INS_OP_W-1:0]  op;
      logic [REG_DAT_W-1:0] pc;
      logic [REG_DAT_W-1:0] imm;
      logic [REG_DAT_W-1:0] vs1;
      logic [REG_DAT_W-1:0] vs2;
      logic [ROB_ADD_W-1:0] qd;
   } iss_t;

   // ALU bus wins a double match; both buses carry the same value for a tag.
   function automatic opnd_t snoop(opnd_t o, cdb_t ex, cdb_t lsb);
      opnd_t r;
      r = o;
      if (!o.rdy) begin
         if (ex.en && ex.qd == o.q) begin
            r.rdy = 1'b1;
            r.v   = ex.vd;
         end else if (lsb.en && lsb.qd == o.q) begin
            r.rdy = 1'b1;
            r.v   = lsb.vd;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rs_sched_if.sv
// Dispatch, broadcast and issue signals of the reservation-station scheduler.
interface rs_sched_if;
   import rs_sched_pkg::*;

   logic                 en;
   logic                 iClr;
   logic                 iDC_En;
   logic [INS_OP_W-1:0]  iDC_Op;
   logic [REG_DAT_W-1:0] iDC_Pc;
   logic [REG_DAT_W-1:0] iDC_Imm;
   logic                 iDC_Rdy1;
   logic                 iDC_Rdy2;
   logic [REG_DAT_W-1:0] iDC_Vs1;
   logic [REG_DAT_W-1:0] iDC_Vs2;
   logic [ROB_ADD_W-1:0] iDC_Qs1;
   logic [ROB_ADD_W-1:0] iDC_Qs2;
   logic [ROB_ADD_W-1:0] iDC_Qd;
   logic                 iEX_En;
   logic [ROB_ADD_W-1:0] iEX_Qd;
   logic [REG_DAT_W-1:0] iEX_Vd;
   logic                 iLSB_En;
   logic [ROB_ADD_W-1:0] iLSB_Qd;
   logic [REG_DAT_W-1:0] iLSB_Vd;
   logic                 oFull;
   logic                 oEX_En;
   logic [INS_OP_W-1:0]  oEX_Op;
   logic [REG_DAT_W-1:0] oEX_Pc;
   logic [REG_DAT_W-1:0] oEX_Imm;
   logic [REG_DAT_W-1:0] oEX_Vs1;
   logic [REG_DAT_W-1:0] oEX_Vs2;
   logic [ROB_ADD_W-1:0] oEX_Qd;

   modport slave (
      input  en, iClr, iDC_En, iDC_Op, iDC_Pc, iDC_Imm, iDC_Rdy1, iDC_Rdy2,
             iDC_Vs1, iDC_Vs2, iDC_Qs1, iDC_Qs2, iDC_Qd,
             iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd,
      output oFull, oEX_En, oEX_Op, oEX_Pc, oEX_Imm, oEX_Vs1, oEX_Vs2, oEX_Qd
   );

   modport master (
      output en, iClr, iDC_En, iDC_Op, iDC_Pc, iDC_Imm, iDC_Rdy1, iDC_Rdy2,
             iDC_Vs1, iDC_Vs2, iDC_Qs1, iDC_Qs2, iDC_Qd,
             iEX_En, iEX_Qd, iEX_Vd, iLSB_En, iLSB_Qd, iLSB_Vd,
      input  oFull, oEX_En, oEX_Op, oEX_Pc, oEX_Imm, oEX_Vs1, oEX_Vs2, oEX_Qd
   );

endinterface

// File: rtl/rs_sched_pick.sv
// rs_pick: combinational rotating picker; first set bit of req searching upward from start, wrapping.
module rs_pick #(
   parameter int N     = 16,
   parameter int IDX_W = 4
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] start,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] cand;

   // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = start + IDX_W'(k);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/rs_sched.sv
// Reservation-station scheduler: dispatch, CDB wakeup and single issue per cycle.
// Define RS_RR_SELECT_EN for round-robin select; default is lowest-index priority.
module rs_sched
   import rs_sched_pkg::*;
#(
   parameter int RS_SIZE  = RS_SIZE_DEF,
   parameter int RS_IDX_W = RS_IDX_W_DEF
) (
   input logic       clk,
   input logic       rst,
   rs_sched_if.slave bus
);

   logic [RS_SIZE-1:0]  busy_q, busy_d, rdy_vec;
   ent_t                ent_q [RS_SIZE];
   ent_t                ent_d [RS_SIZE];
   logic                ex_en_q, ex_en_d;
   iss_t                iss_q, iss_d;
   logic                full, free_found, sel_found;
   logic [RS_IDX_W-1:0] free_idx, sel_idx, sel_start;
   cdb_t                ex_cdb, lsb_cdb;

`ifdef RS_RR_SELECT_EN
   logic [RS_IDX_W-1:0] ptr_q, ptr_d;
   assign sel_start = ptr_q + RS_IDX_W'(1);
`else
   assign sel_start = '0;
`endif

   assign ex_cdb  = '{en: bus.iEX_En,  qd: bus.iEX_Qd,  vd: bus.iEX_Vd};
   assign lsb_cdb = '{en: bus.iLSB_En, qd: bus.iLSB_Qd, vd: bus.iLSB_Vd};
   assign full    = &busy_q;

   always_comb begin
      rdy_vec = '0;
      for (int i = 0; i < RS_SIZE; i++)
         rdy_vec[i] = busy_q[i] & ent_q[i].s1.rdy & ent_q[i].s2.rdy;
   end

   rs_pick #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_pick (
      .req(~busy_q), .start('0), .found(free_found), .idx(free_idx)
   );

   rs_pick #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_sel_pick (
      .req(rdy_vec), .start(sel_start), .found(sel_found), .idx(sel_idx)
   );

   always_comb begin
      busy_d  = busy_q;
      ent_d   = ent_q;
      ex_en_d = ex_en_q;
      iss_d   = iss_q;
`ifdef RS_RR_SELECT_EN
      ptr_d   = ptr_q;
`endif
      if (bus.iClr) begin
         busy_d  = '0;
         ex_en_d = 1'b0;
      end else if (bus.en) begin
         ex_en_d = sel_found;
         if (sel_found) begin
            iss_d = '{op:  ent_q[sel_idx].op,    pc:  ent_q[sel_idx].pc,
                      imm: ent_q[sel_idx].imm,   vs1: ent_q[sel_idx].s1.v,
                      vs2: ent_q[sel_idx].s2.v,  qd:  ent_q[sel_idx].qd};
            busy_d[sel_idx] = 1'b0;
`ifdef RS_RR_SELECT_EN
            ptr_d = sel_idx;
`endif
         end
         for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i].s1 = snoop(ent_q[i].s1, ex_cdb, lsb_cdb);
            ent_d[i].s2 = snoop(ent_q[i].s2, ex_cdb, lsb_cdb);
         end
         // The slot freed by this cycle's issue is not reused until next cycle.
         if (bus.iDC_En && free_found) begin
            busy_d[free_idx]    = 1'b1;
            ent_d[free_idx].op  = bus.iDC_Op;
            ent_d[free_idx].pc  = bus.iDC_Pc;
            ent_d[free_idx].imm = bus.iDC_Imm;
            ent_d[free_idx].qd  = bus.iDC_Qd;
            ent_d[free_idx].s1  = snoop('{rdy: bus.iDC_Rdy1, v: bus.iDC_Vs1, q: bus.iDC_Qs1},
                                        ex_cdb, lsb_cdb);
            ent_d[free_idx].s2  = snoop('{rdy: bus.iDC_Rdy2, v: bus.iDC_Vs2, q: bus.iDC_Qs2},
                                        ex_cdb, lsb_cdb);
         end
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= '0;
         ex_en_q <= 1'b0;
         iss_q   <= '0;
`ifdef RS_RR_SELECT_EN
         ptr_q   <= '1;
`endif
      end else begin
         busy_q  <= busy_d;
         ex_en_q <= ex_en_d;
         iss_q   <= iss_d;
`ifdef RS_RR_SELECT_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   // NOTE: entry payload has no reset; busy bits alone decide whether a slot's contents matter.
   always_ff @(posedge clk) begin
      ent_q <= ent_d;
   end

   always_ff @(posedge clk) begin
      if (!rst && !bus.iClr && bus.en && bus.iDC_En)
         assert (!full) else $error("rs_sched: dispatch while station is full");
   end

   assign bus.oFull   = full;
   assign bus.oEX_En  = ex_en_q;
   assign bus.oEX_Op  = iss_q.op;
   assign bus.oEX_Pc  = iss_q.pc;
   assign bus.oEX_Imm = iss_q.imm;
   assign bus.oEX_Vs1 = iss_q.vs1;
   assign bus.oEX_Vs2 = iss_q.vs2;
   assign bus.oEX_Qd  = iss_q.qd;

endmodule

// File: tb/tb_rs_sched.sv
// Directed self-checking bench for rs_sched; expectations adapt when RS_RR_SELECT_EN is defined.
module tb_rs_sched;
   import rs_sched_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   rs_sched_if dut_if();

   rs_sched dut (.clk(clk), .rst(rst), .bus(dut_if));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      dut_if.iClr    = 1'b0;
      dut_if.iDC_En  = 1'b0;
      dut_if.iEX_En  = 1'b0;
      dut_if.iLSB_En = 1'b0;
   endtask

   task automatic dispatch(input logic [INS_OP_W-1:0] op,
                           input logic r1, input logic [REG_DAT_W-1:0] v1, input logic [ROB_ADD_W-1:0] q1,
                           input logic r2, input logic [REG_DAT_W-1:0] v2, input logic [ROB_ADD_W-1:0] q2,
                           input logic [ROB_ADD_W-1:0] qd);
      dut_if.iDC_En   = 1'b1;
      dut_if.iDC_Op   = op;
      dut_if.iDC_Pc   = 32'h100 + 32'(qd);
      dut_if.iDC_Imm  = 32'h0;
      dut_if.iDC_Rdy1 = r1;
      dut_if.iDC_Vs1  = v1;
      dut_if.iDC_Qs1  = q1;
      dut_if.iDC_Rdy2 = r2;
      dut_if.iDC_Vs2  = v2;
      dut_if.iDC_Qs2  = q2;
      dut_if.iDC_Qd   = qd;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic broadcast_ex(input logic [ROB_ADD_W-1:0] qd, input logic [REG_DAT_W-1:0] vd);
      dut_if.iEX_En = 1'b1;
      dut_if.iEX_Qd = qd;
      dut_if.iEX_Vd = vd;
   endtask

   initial begin
      dut_if.en = 1'b1;
      dispatch(0, 0, 0, 0, 0, 0, 0, 0);
      broadcast_ex(0, 0);
      dut_if.iLSB_Qd = '0;
      dut_if.iLSB_Vd = '0;
      do_reset();

      // Reset state and a fully ready dispatch.
      check("rst_en",   32'(dut_if.oEX_En), 0);
      check("rst_full", 32'(dut_if.oFull), 0);
      check("rst_vs1",  dut_if.oEX_Vs1, 0);
      check("rst_qd",   32'(dut_if.oEX_Qd), 0);
      dispatch(1, 1, 5, 0, 1, 7, 0, 3);
      tick();
      idle();
      check("t1_no_early", 32'(dut_if.oEX_En), 0);
      tick();
      check("t1_en",  32'(dut_if.oEX_En), 1);
      check("t1_op",  32'(dut_if.oEX_Op), 1);
      check("t1_vs1", dut_if.oEX_Vs1, 5);
      check("t1_vs2", dut_if.oEX_Vs2, 7);
      check("t1_qd",  32'(dut_if.oEX_Qd), 3);
      tick();
      check("t1_pulse", 32'(dut_if.oEX_En), 0);
      check("t1_hold",  dut_if.oEX_Vs1, 5);

      // LSB wakeup, with a non-matching ALU broadcast first.
      dispatch(2, 0, 0, 9, 1, 2, 0, 5);
      tick();
      idle();
      check("t2_wait0", 32'(dut_if.oEX_En), 0);
      broadcast_ex(8, 99);
      tick();
      idle();
      check("t2_wait1", 32'(dut_if.oEX_En), 0);
      dut_if.iLSB_En = 1'b1;
      dut_if.iLSB_Qd = 9;
      dut_if.iLSB_Vd = 32'h1234;
      tick();
      idle();
      check("t2_no_bypass", 32'(dut_if.oEX_En), 0);
      tick();
      check("t2_en",  32'(dut_if.oEX_En), 1);
      check("t2_vs1", dut_if.oEX_Vs1, 32'h1234);
      check("t2_vs2", dut_if.oEX_Vs2, 2);
      check("t2_qd",  32'(dut_if.oEX_Qd), 5);

      // Dispatch racing an ALU broadcast for its second operand.
      dispatch(3, 1, 1, 0, 0, 0, 4, 6);
      broadcast_ex(4, 42);
      tick();
      idle();
      tick();
      check("t3_en",  32'(dut_if.oEX_En), 1);
      check("t3_vs2", dut_if.oEX_Vs2, 42);
      check("t3_qd",  32'(dut_if.oEX_Qd), 6);

      // Enable low holds an issued strobe, then holds back a pending issue.
      dispatch(4, 1, 11, 0, 1, 0, 0, 9);
      tick();
      idle();
      tick();
      check("frz_en0", 32'(dut_if.oEX_En), 1);
      dut_if.en = 1'b0;
      tick();
      tick();
      check("frz_hold_en", 32'(dut_if.oEX_En), 1);
      check("frz_hold_qd", 32'(dut_if.oEX_Qd), 9);
      dut_if.en = 1'b1;
      tick();
      check("frz_once", 32'(dut_if.oEX_En), 0);
      dispatch(4, 1, 12, 0, 1, 0, 0, 4);
      tick();
      idle();
      dut_if.en = 1'b0;
      tick();
      check("frz_pend", 32'(dut_if.oEX_En), 0);
      dut_if.en = 1'b1;
      tick();
      check("frz_rel_en", 32'(dut_if.oEX_En), 1);
      check("frz_rel_qd", 32'(dut_if.oEX_Qd), 4);
      tick();

      // Fill all 16 entries waiting on tag 1, then drain in index order.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         dispatch(5, 0, 0, 1, 1, i, 0, ROB_ADD_W'(i));
         tick();
         if (i == 14) check("t4_not_full", 32'(dut_if.oFull), 0);
      end
      idle();
      check("t4_full", 32'(dut_if.oFull), 1);
      broadcast_ex(1, 32'h77);
      tick();
      idle();
      check("t4_bcast_no_issue", 32'(dut_if.oEX_En), 0);
      check("t4_bcast_full", 32'(dut_if.oFull), 1);
      for (int i = 0; i < 16; i++) begin
         tick();
         check($sformatf("t4_en_%0d", i),  32'(dut_if.oEX_En), 1);
         check($sformatf("t4_qd_%0d", i),  32'(dut_if.oEX_Qd), i);
         check($sformatf("t4_vs2_%0d", i), dut_if.oEX_Vs2, i);
         if (i == 0) begin
            check("t4_vs1", dut_if.oEX_Vs1, 32'h77);
            check("t4_full_drop", 32'(dut_if.oFull), 0);
         end
      end
      tick();
      check("t4_drained", 32'(dut_if.oEX_En), 0);

      // Flush with five busy entries and one about to issue; en low at the flush edge.
      for (int i = 0; i < 4; i++) begin
         dispatch(6, 0, 0, 2, 1, 0, 0, ROB_ADD_W'(10 + i));
         tick();
      end
      dispatch(6, 1, 3, 0, 1, 3, 0, 14);
      tick();
      dispatch(6, 1, 3, 0, 1, 3, 0, 15);
      dut_if.iClr = 1'b1;
      dut_if.en   = 1'b0;
      tick();
      idle();
      dut_if.en = 1'b1;
      check("t5_clr_en",   32'(dut_if.oEX_En), 0);
      check("t5_clr_full", 32'(dut_if.oFull), 0);
      broadcast_ex(2, 5);
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("t5_quiet_%0d", i), 32'(dut_if.oEX_En), 0);
      end
      dispatch(7, 1, 1, 0, 1, 1, 0, 7);
      tick();
      idle();
      tick();
      check("t5_new_en", 32'(dut_if.oEX_En), 1);
      check("t5_new_qd", 32'(dut_if.oEX_Qd), 7);

      // Select policy: slots 0..2 woken together, slot 0 refilled after it issues.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         dispatch(8, 0, 0, 14, 1, 0, 0, ROB_ADD_W'(i));
         tick();
      end
      idle();
      broadcast_ex(14, 1);
      tick();
      idle();
      tick();
      check("t6_qd_a", 32'(dut_if.oEX_Qd), 0);
      dispatch(8, 1, 0, 0, 1, 0, 0, 8);
      tick();
      idle();
      check("t6_qd_b", 32'(dut_if.oEX_Qd), 1);
      tick();
      check("t6_en_c", 32'(dut_if.oEX_En), 1);
`ifdef RS_RR_SELECT_EN
      check("t6_qd_c", 32'(dut_if.oEX_Qd), 2);
      tick();
      check("t6_qd_d", 32'(dut_if.oEX_Qd), 8);
`else
      check("t6_qd_c", 32'(dut_if.oEX_Qd), 8);
      tick();
      check("t6_qd_d", 32'(dut_if.oEX_Qd), 2);
`endif
      check("t6_en_d", 32'(dut_if.oEX_En), 1);
      tick();
      check("t6_done", 32'(dut_if.oEX_En), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
